cheer_victory_seq: RTL and testbench

//   Parametrised victory-celebration sequencer for the tug-of-war LED bar.
//   On a win it flashes the winner's end of the bar, then sweeps a single lit LED across it,

---
 rtl/cheer_victory_seq.sv | 165 ++++++++++++++++
 tb/tb_cheer_victory_seq.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/cheer_victory_seq.sv
// Victory-celebration sequencer for the tug-of-war LED bar.
// After a win it flashes the winner's end of the bar, then sweeps one lit LED
// across the bar, paced by slowen512. It repeats LOOPS times, or forever when
// LOOPS==0, and then gives the bar back to the live score.
// Optional build macro: CHEER_BOUNCE_EN makes the sweep go out and back.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | bar shows the live score
// FLASH_ON  | winner's WIN_W LEDs lit
// FLASH_OFF | bar dark between flashes
// SWEEP     | single LED travelling across the bar
// DONE      | one-clk done pulse, then back to IDLE
module cheer_victory_seq #(
   parameter int N_LEDS       = 7,
   parameter int WIN_W        = 3,
   parameter int FLASH_CYCLES = 3,
   parameter int LOOPS        = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              slowen512,
   input  logic              start,
   input  logic              winner_right,
   input  logic [N_LEDS-1:0] score,
   output logic [N_LEDS-1:0] victory_led,
   output logic              busy,
   output logic              done
);

`ifdef CHEER_BOUNCE_EN
   localparam int SWEEP_STEPS = 2*N_LEDS - 1;
`else
   localparam int SWEEP_STEPS = N_LEDS;
`endif
   localparam int FLASH_W = $clog2(FLASH_CYCLES) + 1;
   localparam int SWEEP_W = $clog2(SWEEP_STEPS) + 1;
   localparam int LOOP_W  = $clog2(LOOPS) + 1;

   localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_CYCLES - 1);
   localparam logic [SWEEP_W-1:0] SWEEP_LAST = SWEEP_W'(SWEEP_STEPS - 1);
   localparam logic [SWEEP_W-1:0] FAR_END    = SWEEP_W'(N_LEDS - 1);
   localparam logic [LOOP_W-1:0]  LOOP_LAST  = LOOP_W'((LOOPS == 0) ? 0 : LOOPS - 1);
   localparam logic [LOOP_W-1:0]  LOOP_MAX   = {LOOP_W{1'b1}};

   localparam logic [N_LEDS-1:0] ALL_ON  = {N_LEDS{1'b1}};
   localparam logic [N_LEDS-1:0] FLASH_R = ALL_ON >> (N_LEDS - WIN_W);
   localparam logic [N_LEDS-1:0] FLASH_L = FLASH_R << (N_LEDS - WIN_W);
   localparam logic [N_LEDS-1:0] LED_LSB = N_LEDS'(1);
   localparam logic [N_LEDS-1:0] LED_MSB = LED_LSB << (N_LEDS - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FLASH_ON  = 3'd1,
      FLASH_OFF = 3'd2,
      SWEEP     = 3'd3,
      DONE      = 3'd4
   } state_t;

   state_t              state, state_nxt;
   logic [FLASH_W-1:0]  flash_cnt, flash_nxt;
   logic [SWEEP_W-1:0]  sweep_cnt, sweep_nxt;
   logic [LOOP_W-1:0]   loop_cnt, loop_nxt;
   logic                winner_q, winner_nxt;
   logic [SWEEP_W-1:0]  offs;
   logic [N_LEDS-1:0]   led_nxt;
   logic                busy_nxt;
   logic                done_nxt;

   // Next state and counters; start always wins over a coincident tick.
   always_comb begin
      state_nxt  = state;
      flash_nxt  = flash_cnt;
      sweep_nxt  = sweep_cnt;
      loop_nxt   = loop_cnt;
      winner_nxt = winner_q;
      if (start) begin
         state_nxt  = FLASH_ON;
         winner_nxt = winner_right;
         flash_nxt  = '0;
         sweep_nxt  = '0;
         loop_nxt   = '0;
      end else begin
         case (state)
            FLASH_ON: if (slowen512) state_nxt = FLASH_OFF;
            FLASH_OFF: begin
               if (slowen512) begin
                  if (flash_cnt == FLASH_LAST) begin
                     state_nxt = SWEEP;
                     sweep_nxt = '0;
                  end else begin
                     state_nxt = FLASH_ON;
                     flash_nxt = flash_cnt + FLASH_W'(1);
                  end
               end
            end
            SWEEP: begin
               if (slowen512) begin
                  if (sweep_cnt == SWEEP_LAST) begin
                     if (LOOPS == 0 || loop_cnt < LOOP_LAST) begin
                        state_nxt = FLASH_ON;
                        flash_nxt = '0;
                        sweep_nxt = '0;
                        // saturate so an endless run never wraps
                        if (loop_cnt != LOOP_MAX) loop_nxt = loop_cnt + LOOP_W'(1);
                     end else begin
                        state_nxt = DONE;
                     end
                  end else begin
                     sweep_nxt = sweep_cnt + SWEEP_W'(1);
                  end
               end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // LED pattern and handshake derived from where the FSM is going next.
   always_comb begin
      offs = sweep_nxt;
`ifdef CHEER_BOUNCE_EN
      if (sweep_nxt > FAR_END) offs = SWEEP_LAST - sweep_nxt;
`endif
      led_nxt  = victory_led;
      busy_nxt = 1'b0;
      done_nxt = 1'b0;
      case (state_nxt)
         IDLE:      led_nxt = score;
         FLASH_ON:  begin led_nxt = winner_nxt ? FLASH_R : FLASH_L; busy_nxt = 1'b1; end
         FLASH_OFF: begin led_nxt = '0; busy_nxt = 1'b1; end
         SWEEP:     begin
            led_nxt  = winner_nxt ? (LED_MSB >> offs) : (LED_LSB << offs);
            busy_nxt = 1'b1;
         end
         DONE:      done_nxt = 1'b1;
         default:   led_nxt = '0;
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         flash_cnt   <= '0;
         sweep_cnt   <= '0;
         loop_cnt    <= '0;
         winner_q    <= 1'b0;
         victory_led <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_nxt;
         flash_cnt   <= flash_nxt;
         sweep_cnt   <= sweep_nxt;
         loop_cnt    <= loop_nxt;
         winner_q    <= winner_nxt;
         victory_led <= led_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
      end
   end

endmodule

// File: tb/tb_cheer_victory_seq.sv
// Directed bench for cheer_victory_seq: one instance with LOOPS=1, one with LOOPS=0,
// both driven by the same stimulus.
module tb_cheer_victory_seq;

`ifdef CHEER_BOUNCE_EN
   localparam int L = 19;
`else
   localparam int L = 13;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       slowen512 = 1'b0;
   logic       start = 1'b0;
   logic       winner_right = 1'b0;
   logic [6:0] score = '0;
   logic [6:0] led1, led0;
   logic       busy1, busy0, done1, done0;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   cheer_victory_seq #(.N_LEDS(7), .WIN_W(3), .FLASH_CYCLES(3), .LOOPS(1)) u_dut1 (
      .clk(clk), .rst(rst), .slowen512(slowen512), .start(start),
      .winner_right(winner_right), .score(score),
      .victory_led(led1), .busy(busy1), .done(done1));

   cheer_victory_seq #(.N_LEDS(7), .WIN_W(3), .FLASH_CYCLES(3), .LOOPS(0)) u_dut0 (
      .clk(clk), .rst(rst), .slowen512(slowen512), .start(start),
      .winner_right(winner_right), .score(score),
      .victory_led(led0), .busy(busy0), .done(done0));

   // Expected bar pattern k ticks into a loop (k=0 is the pattern right after start).
   function automatic logic [6:0] exp_led(input int k, input logic right);
      logic [6:0] lsb;
      logic [6:0] msb;
      int s;
      int o;
      lsb = 7'b0000001;
      msb = 7'b1000000;
      if (k < 6) return (k % 2 == 0) ? (right ? 7'b0000111 : 7'b1110000) : 7'b0000000;
      s = k - 6;
      o = (s < 7) ? s : 12 - s;
      return right ? (msb >> o) : (lsb << o);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse(input logic t, input logic s);
      slowen512 = t;
      start = s;
      @(posedge clk);
      #1;
      slowen512 = 1'b0;
      start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // reset dominates start and tick
      rst = 1'b0; start = 1'b1; slowen512 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk("rst_led1", led1, 7'b0); chk("rst_busy1", busy1, 0); chk("rst_done1", done1, 0);
         chk("rst_led0", led0, 7'b0); chk("rst_busy0", busy0, 0); chk("rst_done0", done0, 0);
      end
      rst = 1'b1; start = 1'b0; slowen512 = 1'b0; score = 7'b0011100;
      idle(1);
      chk("idle_score", led1, 7'b0011100);
      pulse(1'b1, 1'b0);
      chk("idle_tick_led", led1, 7'b0011100);
      chk("idle_tick_busy", busy1, 0);

      // finite run, right winner
      winner_right = 1'b1;
      pulse(1'b0, 1'b1);
      chk("t2_start_led", led1, exp_led(0, 1'b1));
      chk("t2_start_busy", busy1, 1);
      idle(3);
      for (int t = 1; t <= L; t++) begin
         pulse(1'b1, 1'b0);
         if (t == 3) score = 7'b1111111;
         if (t < L) begin
            chk("t2_led", led1, exp_led(t, 1'b1));
            chk("t2_busy", busy1, 1);
            chk("t2_done", done1, 0);
         end else begin
            chk("t2_done_pulse", done1, 1);
            chk("t2_busy_fall", busy1, 0);
         end
         idle(t < L ? 3 : 1);
      end
      chk("t2_done_once", done1, 0);
      chk("t2_back_score", led1, 7'b1111111);

      // endless run, left winner
      winner_right = 1'b0;
      pulse(1'b0, 1'b1);
      chk("t3_start_led", led0, 7'b1110000);
      for (int t = 1; t <= 3*L; t++) begin
         pulse(1'b1, 1'b0);
         chk("t3_led", led0, exp_led(t % L, 1'b0));
         chk("t3_busy", busy0, 1);
         chk("t3_done", done0, 0);
      end

      // mid-sweep restart
      winner_right = 1'b1;
      pulse(1'b0, 1'b1);
      for (int t = 1; t <= 9; t++) pulse(1'b1, 1'b0);
      chk("t4_sweep_pos", led0, 7'b0001000);
      winner_right = 1'b0;
      pulse(1'b0, 1'b1);
      chk("t4_restart_led", led0, 7'b1110000);
      chk("t4_restart_busy", busy0, 1);
      chk("t4_no_done0", done0, 0);
      chk("t4_no_done1", done1, 0);
      for (int t = 1; t <= 6; t++) begin
         pulse(1'b1, 1'b0);
         chk("t4_led", led0, exp_led(t, 1'b0));
      end

      // start coincident with tick
      winner_right = 1'b1;
      pulse(1'b1, 1'b1);
      chk("t5_coinc_led", led0, 7'b0000111);
      chk("t5_coinc_busy", busy0, 1);
      pulse(1'b1, 1'b0);
      chk("t5_next_tick", led0, 7'b0000000);

      // reset mid-run
      rst = 1'b0;
      idle(1);
      chk("rst2_led0", led0, 7'b0); chk("rst2_busy0", busy0, 0);
      chk("rst2_led1", led1, 7'b0); chk("rst2_busy1", busy1, 0);
      rst = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
